// File: rtl/key_conditioner.sv
// Push-button conditioner: per-key 2-FF synchronizer, press/release debounce FSM
// and one-shot active-low strobe, plus the registered debounced level.
module key_conditioner #(
  parameter  int N_KEYS    = 2,
  parameter  int DB_CYCLES = 1_000_000,
  localparam int CW        = $clog2(DB_CYCLES)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [N_KEYS-1:0] nKeyIn,
  output logic [N_KEYS-1:0] fKeyOut,
  output logic [N_KEYS-1:0] KeyLevel
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_e;

  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] ks_q;

  // Synchronizers idle high so that reset looks like "nothing pressed".
  // NOTE: sequential state is always written with <= so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sync1_q <= '1;
      ks_q    <= '1;
    end else begin
      sync1_q <= nKeyIn;
      ks_q    <= sync1_q;
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            strobe_q, strobe_d;
    logic            level_q, level_d;

    // Every path out of a wait state at CNT_LAST leaves that state, so the
    // counter can never wrap.
    always_comb begin
      // NOTE: all outputs get a default before the case so no path leaves a
      // variable unassigned, which would otherwise infer a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      strobe_d = 1'b1;
      level_d  = level_q;
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (!ks_q[i]) state_d = PRESS_WAIT;
        end
        PRESS_WAIT: begin
          if (ks_q[i]) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d  = HELD;
            cnt_d    = '0;
            strobe_d = 1'b0;
            level_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        HELD: begin
          cnt_d = '0;
          if (ks_q[i]) state_d = RELEASE_WAIT;
        end
        RELEASE_WAIT: begin
          if (!ks_q[i]) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            level_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b1;
        end
      endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        strobe_q <= 1'b1;
        level_q  <= 1'b1;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        strobe_q <= strobe_d;
        level_q  <= level_d;
      end
    end

    assign fKeyOut[i]  = strobe_q;
    assign KeyLevel[i] = level_q;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios with hand-counted edge latencies,
// then random key bouncing and resets checked every cycle against a run-length model.
module tb_key_conditioner;

  localparam int N_KEYS = 2;
  localparam int DB     = 4;

  logic              Clk = 1'b0;
  logic              Rst = 1'b1;
  logic [N_KEYS-1:0] nKeyIn = '1;
  logic [N_KEYS-1:0] fKeyOut;
  logic [N_KEYS-1:0] KeyLevel;

  key_conditioner #(
    .N_KEYS   (N_KEYS),
    .DB_CYCLES(DB)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .nKeyIn  (nKeyIn),
    .fKeyOut (fKeyOut),
    .KeyLevel(KeyLevel)
  );

  always #10 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw input reaches the debouncer two samples late; the accepted
  // level flips once DB+1 consecutive samples disagree with it, and a flip to
  // "pressed" produces a one-cycle low strobe.
  logic [N_KEYS-1:0] m_raw1, m_raw2;
  logic [N_KEYS-1:0] m_level, m_strobe;
  int                m_run[N_KEYS];

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      m_raw1   = '1;
      m_raw2   = '1;
      m_level  = '1;
      m_strobe = '1;
      for (int k = 0; k < N_KEYS; k++) m_run[k] = 0;
    end else begin
      for (int k = 0; k < N_KEYS; k++) begin
        m_strobe[k] = 1'b1;
        if (m_raw2[k] != m_level[k]) begin
          m_run[k]++;
          if (m_run[k] == DB + 1) begin
            m_level[k] = m_raw2[k];
            m_run[k]   = 0;
            if (!m_raw2[k]) m_strobe[k] = 1'b0;
          end
        end else begin
          m_run[k] = 0;
        end
      end
      m_raw2 = m_raw1;
      m_raw1 = nKeyIn;
    end
  end

  int strobes[N_KEYS];
  initial for (int k = 0; k < N_KEYS; k++) strobes[k] = 0;

  always @(negedge Clk) begin
    check("model_fKeyOut", fKeyOut, m_strobe);
    check("model_KeyLevel", KeyLevel, m_level);
    for (int k = 0; k < N_KEYS; k++) if (!fKeyOut[k]) strobes[k]++;
  end

  // Counts edges from the call; edge 1 is the first posedge after the caller
  // changed the inputs. Returns -1 for events that never happened.
  task automatic measure(input int k, input int limit,
                         output int low_e, output int high_e, output int lvl_e);
    logic start_lvl;
    start_lvl = KeyLevel[k];
    low_e = -1; high_e = -1; lvl_e = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge Clk);
      #1;
      if (low_e < 0 && fKeyOut[k] == 1'b0) low_e = i;
      else if (low_e >= 0 && high_e < 0 && fKeyOut[k] == 1'b1) high_e = i;
      if (lvl_e < 0 && KeyLevel[k] != start_lvl) lvl_e = i;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int lo, hi, lv, s0, s1, both_e;
    int hold[N_KEYS];

    // Reset and idle
    nKeyIn = 2'b00;
    #1 Rst = 1'b0;
    repeat (3) @(negedge Clk);
    check("reset_fKeyOut", fKeyOut, 2'b11);
    check("reset_KeyLevel", KeyLevel, 2'b11);
    nKeyIn = 2'b11;
    @(negedge Clk) Rst = 1'b1;
    repeat (50) @(negedge Clk);
    check("idle_no_strobe", strobes[0] + strobes[1], 0);
    check("idle_KeyLevel", KeyLevel, 2'b11);

    // Clean press on key 0
    s0 = strobes[0]; s1 = strobes[1];
    nKeyIn[0] = 1'b0;
    measure(0, 20, lo, hi, lv);
    check("press_low_edge", lo, 7);
    check("press_high_edge", hi, 8);
    check("press_level_edge", lv, 7);
    check("press_one_strobe", strobes[0] - s0, 1);
    check("press_other_key_quiet", strobes[1] - s1, 0);

    // Release bounce, then clean release
    @(negedge Clk);
    s0 = strobes[0];
    nKeyIn[0] = 1'b1;
    repeat (2) @(negedge Clk);
    nKeyIn[0] = 1'b0;
    repeat (10) @(negedge Clk);
    check("relbounce_still_held", KeyLevel[0], 1'b0);
    nKeyIn[0] = 1'b1;
    measure(0, 20, lo, hi, lv);
    check("release_level_edge", lv, 7);
    check("release_no_strobe", lo, -1);
    check("relbounce_no_second", strobes[0] - s0, 0);

    // Bounce rejection: toggle every 2 cycles
    @(negedge Clk);
    s0 = strobes[0];
    for (int c = 0; c < 40; c++) begin
      nKeyIn[0] = c[1];
      @(negedge Clk);
      check("bounce_level_high", KeyLevel[0], 1'b1);
    end
    nKeyIn[0] = 1'b1;
    repeat (20) @(negedge Clk);
    check("bounce_no_strobe", strobes[0] - s0, 0);

    // Simultaneous keys
    s0 = strobes[0]; s1 = strobes[1];
    nKeyIn = 2'b00;
    both_e = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge Clk);
      #1;
      if (both_e < 0 && fKeyOut == 2'b00) both_e = i;
    end
    check("simul_same_edge", both_e, 7);
    check("simul_key0_once", strobes[0] - s0, 1);
    check("simul_key1_once", strobes[1] - s1, 1);
    @(negedge Clk) nKeyIn = 2'b11;
    repeat (20) @(negedge Clk);

    // Reset mid-press on key 1
    s1 = strobes[1];
    nKeyIn[1] = 1'b0;
    repeat (5) @(posedge Clk);
    @(negedge Clk) Rst = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      check("midreset_fKeyOut", fKeyOut, 2'b11);
      check("midreset_KeyLevel", KeyLevel, 2'b11);
    end
    Rst = 1'b1;
    measure(1, 20, lo, hi, lv);
    check("midreset_low_edge", lo, 7);
    check("midreset_high_edge", hi, 8);
    check("midreset_one_strobe", strobes[1] - s1, 1);
    @(negedge Clk) nKeyIn = 2'b11;
    repeat (20) @(negedge Clk);

    // Random bouncing with occasional asynchronous resets
    s0 = strobes[0] + strobes[1];
    for (int k = 0; k < N_KEYS; k++) hold[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clk);
      for (int k = 0; k < N_KEYS; k++) begin
        if (hold[k] == 0) begin
          nKeyIn[k] = 1'($urandom_range(0, 1));
          hold[k]   = int'($urandom_range(1, 9));
        end else begin
          hold[k]--;
        end
      end
      if ($urandom_range(0, 599) == 0) begin
        #3 Rst = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
      end
    end
    nKeyIn = 2'b11;
    repeat (20) @(negedge Clk);
    check("random_saw_strobes", (strobes[0] + strobes[1] - s0) > 0, 1);
    check("random_final_level", KeyLevel, 2'b11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
Conditions raw active-low push-button inputs into clean, single-clock, active-low command strobes for the stopwatch core. The block sits directly upstream of the stopwatch, and its outputs drive the fStart/fStop inputs. Each key gets:
- a 2-FF synchronizer,
- an independent press/release debounce FSM with a shared-width counter,
- a one-shot pulse generator.
It also exports the debounced key levels.

Parameters:
N_KEYS, 2, number of independent keys; bit 0 = start, bit 1 = stop.
DB_CYCLES, 1_000_000, stable-level cycles required to accept a press or release (20 ms at 50 MHz); legal minimum is 2; benches override it to 4.
CW, $clog2(DB_CYCLES), debounce counter width; derived, never overridden.

Ports:
Clk  input  1  system clock, 50 MHz.
Rst  input  1  asynchronous, active-low reset.
nKeyIn  input  N_KEYS  raw button levels, asynchronous to Clk; 0 = pressed.
fKeyOut  output  N_KEYS  per-key strobe; idles 1; low for exactly one Clk cycle per accepted press; registered.
KeyLevel  output  N_KEYS  debounced level; 0 = pressed; registered.

Behaviour:
- One clock domain. Rst is asynchronous and active-low. While Rst=0:
  - every FSM is in IDLE;
  - all synchronizer FFs = 1;
  - counters = 0;
  - fKeyOut = all 1s;
  - KeyLevel = all 1s.
- Synchronizer: nKeyIn[i] passes through two FFs, giving ks[i]. Only ks[i] is used downstream.
- Per-key FSM (four states, CW-bit counter cnt):
  - IDLE: KeyLevel=1. If ks=0, go to PRESS_WAIT with cnt=0.
  - PRESS_WAIT:
    - ks=1 → IDLE, cnt=0 (bounce rejected, no pulse).
    - ks=0 and cnt<DB_CYCLES-1 → cnt+1.
    - ks=0 and cnt==DB_CYCLES-1 → HELD. On the same edge fKeyOut[i]<=0 and KeyLevel[i]<=0.
  - HELD: fKeyOut[i] returns to 1 on the next edge, unconditionally. If ks=1, go to RELEASE_WAIT with cnt=0.
  - RELEASE_WAIT:
    - ks=0 → HELD, cnt=0, no new pulse.
    - ks=1 and cnt==DB_CYCLES-1 → IDLE, KeyLevel[i]<=1.
    - otherwise cnt+1.
- Latency: number as edge 1 the first rising edge at which the first sync FF samples nKeyIn low. If the input then stays low, fKeyOut goes low on edge DB_CYCLES+3 and high on edge DB_CYCLES+4. With DB_CYCLES=4, the strobe is low between edges 7 and 8.
- Release latency has the same structure: KeyLevel returns to 1 on edge DB_CYCLES+3 after the release is first sampled.
- One strobe per press. Holding a key indefinitely never repeats. A glitch high shorter than DB_CYCLES during the hold produces no extra strobe.
- Counter never wraps. It saturates logic-wise because every path at DB_CYCLES-1 changes state.
- Keys are fully independent. Simultaneous presses may strobe in the same cycle, with no priority or masking.
- Reset mid-operation: the FSM returns to IDLE and any strobe in progress is cut. A key still held after Rst rises is treated as a new press and strobes once, DB_CYCLES+3 edges after release of reset.
- No combinational path from nKeyIn to any output.

Test Plan:
All scenarios use DB_CYCLES=4 and a 20 ns clock.
1. Reset and idle: Rst=0 with nKeyIn=2'b00, then Rst=1 with nKeyIn=2'b11 for 50 cycles → fKeyOut=2'b11 and KeyLevel=2'b11 throughout.
2. Clean press: nKeyIn[0]=0 held for 20 cycles → exactly one fKeyOut[0]=0 cycle, between edges 7 and 8. KeyLevel[0]=0 from edge 7. fKeyOut[1] stays 1.
3. Bounce rejection: nKeyIn[0] toggles 0/1 every 2 cycles for 40 cycles, then stays 1 → no strobe and KeyLevel[0]=1 throughout.
4. Release bounce: after scenario 2, nKeyIn[0]=1 for 2 cycles, then 0 for 10 cycles, then 1 for 20 cycles → no second strobe. KeyLevel[0] returns to 1 seven edges after the final release is sampled.
5. Simultaneous keys: nKeyIn=2'b00 on the same edge → both fKeyOut bits low in the same single cycle.
6. Reset mid-press: hold nKeyIn[1]=0 and assert Rst=0 at cycle 5 of PRESS_WAIT, release after 3 cycles → outputs are 1s during reset, then one fKeyOut[1] strobe seven edges after Rst rises.
